// File: rtl/uart_core_param_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core_param_if
//  Description : Handshake/serial bundle for uart_core_param. The master side
//                is the SFR FIFO / line side, the slave side is the UART core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_core_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 txd;
    logic                 rxd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output tx_data, tx_valid, rxd, rx_ready,
        input  tx_ready, tx_busy, txd, rx_data, rx_valid,
        input  rx_parity_err, rx_frame_err, rx_overrun
    );

    modport slave (
        input  tx_data, tx_valid, rxd, rx_ready,
        output tx_ready, tx_busy, txd, rx_data, rx_valid,
        output rx_parity_err, rx_frame_err, rx_overrun
    );
endinterface
`default_nettype wire

// File: rtl/uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_core_param
//  Description : Parametrised full-duplex UART (data width, parity, stop bits,
//                oversampling) with valid/ready FIFO handshakes, RX false-start
//                rejection and parity/framing/overrun flags.
//                Optional build macro UART_RX_MAJORITY_EN: each RX decision is
//                a 2-of-3 vote over three consecutive oversample ticks.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_core_param #(
    parameter int CLK_DIV   = 4,
    parameter int OVS       = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 1,
    parameter int STOP_BITS = 1
) (
    input  wire                clk_uart,
    input  wire                rst_n,
    uart_core_param_if.slave   bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(STOP_BITS * OVS + 1);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] c_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(OVS - 1);
    localparam logic [CNT_W-1:0] c_STOP_LAST = CNT_W'(STOP_BITS * OVS - 1);
    localparam logic [IDX_W-1:0] c_DATA_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    logic [DIV_W-1:0]     r_div_cnt;
    logic                 w_tick;
    tx_state_t            r_tx_state, w_tx_next;
    logic [CNT_W-1:0]     r_tx_cnt;
    logic [IDX_W-1:0]     r_tx_idx;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic                 r_tx_par, w_tx_bit_done, w_txd;
    logic                 r_rxd_meta, r_rxd_sync, w_rx_bit, w_rx_sample, w_rx_done;
    rx_state_t            r_rx_state, w_rx_next;
    logic [CNT_W-1:0]     r_rx_cnt;
    logic [IDX_W-1:0]     r_rx_idx;
    logic [DATA_BITS-1:0] r_rx_shift, r_rx_data;
    logic                 r_rx_par, w_par_exp, w_par_err;
    logic                 r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_overrun;

    // Free-running oversample tick divider shared by TX and RX
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n)                     r_div_cnt <= '0;
        else if (r_div_cnt == c_DIV_LAST) r_div_cnt <= '0;
        else                            r_div_cnt <= r_div_cnt + 1'b1;
    end
    assign w_tick = (r_div_cnt == c_DIV_LAST);

    // ---------------------------------------------------------------- TX ----
    assign w_tx_bit_done = w_tick &&
        (r_tx_cnt == ((r_tx_state == TX_STOP) ? c_STOP_LAST : c_BIT_LAST));

    // TX state register
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) r_tx_state <= TX_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    // TX next-state and serial line level decode
    always_comb begin
        w_tx_next = r_tx_state;
        w_txd     = 1'b1;
        case (r_tx_state)
            TX_IDLE:   if (bus.tx_valid) w_tx_next = TX_START;
            TX_START: begin
                w_txd = 1'b0;
                if (w_tx_bit_done) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_txd = r_tx_shift[0];
                if (w_tx_bit_done && (r_tx_idx == c_DATA_LAST))
                    w_tx_next = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                w_txd = r_tx_par;
                if (w_tx_bit_done) w_tx_next = TX_STOP;
            end
            TX_STOP:   if (w_tx_bit_done) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: latch word and parity on accept, shift LSB first per bit
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
        end else if (r_tx_state == TX_IDLE) begin
            r_tx_cnt <= '0;
            r_tx_idx <= '0;
            if (bus.tx_valid) begin
                r_tx_shift <= bus.tx_data;
                r_tx_par   <= (PARITY == 2) ? ^bus.tx_data : ~^bus.tx_data;
            end
        end else if (w_tx_bit_done) begin
            r_tx_cnt <= '0;
            if (r_tx_state == TX_DATA) begin
                r_tx_shift <= r_tx_shift >> 1;
                r_tx_idx   <= r_tx_idx + 1'b1;
            end
        end else if (w_tick) begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    // txd is decoded purely from flops (state, shift[0], parity)
    assign bus.txd      = w_txd;
    assign bus.tx_ready = (r_tx_state == TX_IDLE);
    assign bus.tx_busy  = (r_tx_state != TX_IDLE);

    // ---------------------------------------------------------------- RX ----
    // Two-flop synchroniser for the asynchronous serial input, idles high
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= bus.rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // Decision lands one tick after mid-bit so the three votes straddle it
    localparam logic [CNT_W-1:0] c_RX_FIRST = CNT_W'(OVS / 2);
    logic [1:0] r_rx_hist;

    // History of the two previous tick samples for the 2-of-3 vote
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n)      r_rx_hist <= 2'b11;
        else if (w_tick) r_rx_hist <= {r_rx_hist[0], r_rxd_sync};
    end
    assign w_rx_bit = (r_rx_hist[1] & r_rx_hist[0]) | (r_rx_hist[1] & r_rxd_sync) |
                      (r_rx_hist[0] & r_rxd_sync);
`else
    localparam logic [CNT_W-1:0] c_RX_FIRST = CNT_W'(OVS / 2 - 1);
    assign w_rx_bit = r_rxd_sync;
`endif

    // After the start decision every later decision is a full bit apart
    assign w_rx_sample = w_tick &&
        (r_rx_cnt == ((r_rx_state == RX_START) ? c_RX_FIRST : c_BIT_LAST));

    // RX state register
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) r_rx_state <= RX_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    // RX next-state and frame-completion strobe
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_done = 1'b0;
        case (r_rx_state)
            RX_IDLE:   if (!r_rxd_sync) w_rx_next = RX_START;
            RX_START:  if (w_rx_sample) w_rx_next = w_rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:
                if (w_rx_sample && (r_rx_idx == c_DATA_LAST))
                    w_rx_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_rx_sample) w_rx_next = RX_STOP;
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_next = RX_IDLE;
                    w_rx_done = 1'b1;
                end
            end
            default:   w_rx_next = RX_IDLE;
        endcase
    end

    // RX datapath: tick counter, LSB-first shifter and captured parity bit
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_par   <= 1'b0;
        end else if (r_rx_state == RX_IDLE) begin
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
        end else if (w_rx_sample) begin
            r_rx_cnt <= '0;
            if (r_rx_state == RX_DATA) begin
                r_rx_shift <= {w_rx_bit, r_rx_shift[DATA_BITS-1:1]};
                r_rx_idx   <= r_rx_idx + 1'b1;
            end
            if (r_rx_state == RX_PARITY) r_rx_par <= w_rx_bit;
        end else if (w_tick) begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

    assign w_par_exp = (PARITY == 2) ? ^r_rx_shift : ~^r_rx_shift;
    assign w_par_err = (PARITY != 0) && (r_rx_par != w_par_exp);

    // Output holding register: load on completion unless the held word is unread
    always_ff @(posedge clk_uart or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_perr    <= 1'b0;
            r_rx_ferr    <= 1'b0;
            r_rx_overrun <= 1'b0;
        end else begin
            r_rx_overrun <= 1'b0;
            if (w_rx_done) begin
                if (!r_rx_valid || bus.rx_ready) begin
                    r_rx_data  <= r_rx_shift;
                    r_rx_perr  <= w_par_err;
                    r_rx_ferr  <= !w_rx_bit;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (r_rx_valid && bus.rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
    assign bus.rx_overrun    = r_rx_overrun;
endmodule
`default_nettype wire

// File: tb/tb_uart_core_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_core_param
//  Description : Self-checking bench for uart_core_param (default parameters):
//                TX bit pattern, loopback, framing/parity errors, overrun,
//                false start and asynchronous reset mid-frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core_param;
    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       r_loop;
    logic       r_drv_rxd;
    rx_exp_t    q_exp[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_hs     = 0;
    int         n_ovr    = 0;

    uart_core_param_if #(.DATA_BITS(8)) u_if ();

    uart_core_param #(
        .CLK_DIV(4), .OVS(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)
    ) u_dut (
        .clk_uart (clk),
        .rst_n    (rst_n),
        .bus      (u_if)
    );

    assign u_if.rxd = r_loop ? u_if.txd : r_drv_rxd;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return (ones % 2 == 0);
    endfunction

    // Scoreboard monitor: every accepted RX word is compared with the queue head
    always @(negedge clk) begin
        if (rst_n && u_if.rx_valid && u_if.rx_ready) begin
            n_hs++;
            n_checks++;
            if (q_exp.size() == 0) begin
                n_errors++;
                $display("FAIL rx_unexpected: got data %h perr %b ferr %b, none expected",
                         u_if.rx_data, u_if.rx_parity_err, u_if.rx_frame_err);
            end else begin
                rx_exp_t e;
                e = q_exp.pop_front();
                if ({u_if.rx_data, u_if.rx_parity_err, u_if.rx_frame_err} !== e) begin
                    n_errors++;
                    $display("FAIL rx_frame: got data %h perr %b ferr %b, expected data %h perr %b ferr %b",
                             u_if.rx_data, u_if.rx_parity_err, u_if.rx_frame_err,
                             e.data, e.perr, e.ferr);
                end
            end
        end
        if (rst_n && u_if.rx_overrun) n_ovr++;
    end

    // Present a word and hold tx_valid until the accepting edge has passed
    task automatic tx_push(input logic [7:0] d);
        int guard = 0;
        u_if.tx_data  = d;
        u_if.tx_valid = 1'b1;
        while (!u_if.tx_ready && guard < 2000) begin
            cycles(1);
            guard++;
        end
        if (guard >= 2000) begin
            n_checks++;
            n_errors++;
            $display("FAIL tx_accept_timeout: got tx_ready 0 expected 1");
        end
        cycles(1);
    endtask

    // Bit-bang one frame on rxd; a low stop bit is held 40 clocks then released
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_ok);
        r_drv_rxd = 1'b0;
        cycles(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            r_drv_rxd = d[i];
            cycles(BIT_CLK);
        end
        r_drv_rxd = p;
        cycles(BIT_CLK);
        r_drv_rxd = stop_ok;
        cycles(stop_ok ? BIT_CLK : 40);
        r_drv_rxd = 1'b1;
        cycles(BIT_CLK);
    endtask

    task automatic wait_drain(input int limit);
        int guard = 0;
        while (q_exp.size() > 0 && guard < limit) begin
            cycles(1);
            guard++;
        end
        if (guard >= limit) begin
            n_checks++;
            n_errors++;
            $display("FAIL rx_drain_timeout: got %0d pending expected 0", q_exp.size());
        end
    endtask

    initial begin
        logic [10:0] exp_bits;
        int          cyc;
        int          n0;

        rst_n          = 1'b0;
        r_loop         = 1'b0;
        r_drv_rxd      = 1'b1;
        u_if.tx_data   = '0;
        u_if.tx_valid  = 1'b0;
        u_if.rx_ready  = 1'b1;
        cycles(3);

        // Reset state
        chk("rst_txd",      32'(u_if.txd),           32'd1);
        chk("rst_tx_ready", 32'(u_if.tx_ready),      32'd1);
        chk("rst_tx_busy",  32'(u_if.tx_busy),       32'd0);
        chk("rst_rx_valid", 32'(u_if.rx_valid),      32'd0);
        chk("rst_rx_data",  32'(u_if.rx_data),       32'd0);
        chk("rst_errs",     32'({u_if.rx_parity_err, u_if.rx_frame_err, u_if.rx_overrun}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(5);

        // TX waveform for 8'hA5: start, LSB-first data, odd parity 1, stop
        exp_bits = {1'b1, 1'b1, 8'hA5, 1'b0};
        tx_push(8'hA5);
        u_if.tx_valid = 1'b0;
        cyc = 0;
        for (int k = 0; k < 11; k++) begin
            while (cyc < k * BIT_CLK + BIT_CLK / 2) begin
                cycles(1);
                cyc++;
            end
            chk($sformatf("tx_bit%0d", k), 32'(u_if.txd), 32'(exp_bits[k]));
            if (k == 5) chk("tx_busy_mid", 32'(u_if.tx_busy), 32'd1);
        end
        while (!u_if.tx_ready && cyc < 1000) begin
            cycles(1);
            cyc++;
        end
        n_checks++;
        if (!(cyc >= 700 && cyc <= 704)) begin
            n_errors++;
            $display("FAIL tx_frame_len: got %0d clocks expected 700..704", cyc);
        end
        cycles(20);

        // Loopback, back-to-back 3C then C3
        r_loop = 1'b1;
        q_exp.push_back('{data: 8'h3C, perr: 1'b0, ferr: 1'b0});
        q_exp.push_back('{data: 8'hC3, perr: 1'b0, ferr: 1'b0});
        tx_push(8'h3C);
        tx_push(8'hC3);
        u_if.tx_valid = 1'b0;
        wait_drain(3000);
        cycles(100);
        r_loop = 1'b0;
        cycles(20);

        // Framing error: 8'h55, correct parity, stop bit low
        q_exp.push_back('{data: 8'h55, perr: 1'b0, ferr: 1'b1});
        send_frame(8'h55, odd_par(8'h55), 1'b0);
        wait_drain(500);
        cycles(20);

        // Parity error: 8'h01 sent with even parity into an odd-parity receiver
        q_exp.push_back('{data: 8'h01, perr: 1'b1, ferr: 1'b0});
        send_frame(8'h01, ~odd_par(8'h01), 1'b1);
        wait_drain(500);
        cycles(20);

        // Overrun: consumer stalled, second frame dropped
        u_if.rx_ready = 1'b0;
        n0 = n_ovr;
        q_exp.push_back('{data: 8'h11, perr: 1'b0, ferr: 1'b0});
        send_frame(8'h11, odd_par(8'h11), 1'b1);
        send_frame(8'h22, odd_par(8'h22), 1'b1);
        chk("ovr_rx_data",  32'(u_if.rx_data),  32'h11);
        chk("ovr_rx_valid", 32'(u_if.rx_valid), 32'd1);
        chk("ovr_pulses",   32'(n_ovr - n0),    32'd1);
        u_if.rx_ready = 1'b1;
        wait_drain(100);
        cycles(2);
        chk("ovr_valid_clr", 32'(u_if.rx_valid), 32'd0);

        // False start: 20-clock low glitch must not produce a word
        n0 = n_hs;
        r_drv_rxd = 1'b0;
        cycles(20);
        r_drv_rxd = 1'b1;
        cycles(300);
        chk("false_start", 32'(n_hs - n0), 32'd0);

        // Asynchronous reset in the middle of a TX frame
        tx_push(8'h5A);
        u_if.tx_valid = 1'b0;
        cycles(200);
        chk("pre_rst_busy", 32'(u_if.tx_busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_txd",      32'(u_if.txd),      32'd1);
        chk("arst_tx_ready", 32'(u_if.tx_ready), 32'd1);
        chk("arst_tx_busy",  32'(u_if.tx_busy),  32'd0);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(BIT_CLK);
        chk("post_rst_txd", 32'(u_if.txd), 32'd1);

        chk("queue_empty", 32'(q_exp.size()), 32'd0);
        chk("ovr_total",   32'(n_ovr),        32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
